digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 16, total operand/result width in bits.
REQ-002 Parameter: DIGIT, default 4, bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, else elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operands a, b, cin, sub are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in, add mode only.
REQ-010 sub  input  1  0 = A+B+cin; 1 = A-B, with cin ignored.
REQ-011 out_valid  output  1  result fields are valid.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 s  output  WIDTH  sum/difference.
REQ-014 cout  output  1  final carry-out; in sub mode 1 means no borrow.
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 Define NDIG = WIDTH/DIGIT; the FSM states SHALL be IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in RUN and DONE, and while rst_n=0, in_ready SHALL be 0.
REQ-018 On accept (in_valid=1 and in_ready=1), capture A, B' = sub ? ~b : b, and carry = sub ? 1 : cin, then go to RUN with digit index 0.
REQ-019 Inputs SHALL be ignored outside the accept cycle; operand changes after accept SHALL NOT affect the result.
REQ-020 Each RUN cycle, add digit k of A and B' plus the held carry, store DIGIT result bits at s[k*DIGIT +: DIGIT], register the digit carry-out as the new held carry, and increment k.
REQ-021 After digit NDIG-1, go to DONE; out_valid SHALL rise exactly NDIG cycles after the accept edge.
REQ-022 In DONE, cout SHALL be the final held carry.
REQ-023 In DONE, ovf = (A[MSB]==B'[MSB]) and (s[MSB]!=A[MSB]).
REQ-024 In DONE, out_valid=1, and s, cout and ovf SHALL be held stable until out_ready=1.
REQ-025 When out_valid=1 and out_ready=1, return to IDLE; out_valid SHALL be 0 the next cycle, with no accept in that same cycle.
REQ-026 out_ready SHALL be ignored when out_valid=0; out_valid SHALL never be 1 outside DONE.
REQ-027 When DIGIT==WIDTH, RUN SHALL last exactly one cycle (latency 1).
REQ-028 s, cout and ovf SHALL retain their last DONE values after handoff until overwritten by the next operation.

Reset
REQ-029 When rst_n=0 at a clock edge: state IDLE, digit index 0, held carry 0, s=0, cout=0, ovf=0, out_valid=0.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid pulse for it SHALL ever appear.
REQ-031 in_ready SHALL be 1 on the first cycle with rst_n=1 after reset.

Structure
REQ-032 A shared package, digit_serial_pkg, SHALL hold the FSM state encoding (IDLE/RUN/DONE) and the NDIG and index-width derivation functions.
REQ-033 The per-digit combinational add SHALL be a sub-module, digit_add_slice (DIGIT-wide a, b, carry-in; DIGIT-wide sum, carry-out), instantiated once.
REQ-034 The datapath SHALL use no WIDTH-wide adder; only the one DIGIT-wide slice.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-035 Add: a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after accept; s=0x0000, cout=1, ovf=0.
REQ-036 Signed overflow: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; separately cin=1 with a=0x0000, b=0x0000 -> s=0x0001.
REQ-037 Subtract: sub=1, a=0x0005, b=0x0007, cin=1 -> s=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-038 Backpressure: hold out_ready=0 for 5 cycles in DONE -> s, cout and ovf stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1, next operation correct.
REQ-039 Reset mid-RUN: drop rst_n during digit 2 -> out_valid never asserts; in_ready=1 on the first cycle after release; a=0x1234, b=0x1111 -> s=0x2345.
REQ-040 DIGIT=WIDTH=8: a=0x80, b=0x80 -> out_valid 1 cycle after accept; s=0x00, cout=1, ovf=1.

Source files
------------

// File: rtl/digit_serial_pkg.sv
// Shared FSM encoding and sizing helpers for the digit-serial adder.
package digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig_f(input int width, input int digit);
        return width / digit;
    endfunction

    // Keep the index at least one bit wide so the single-digit case still elaborates.
    function automatic int idx_width_f(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_add_slice.sv
// One DIGIT-wide ripple slice: sum and carry-out of a + b + ci.
// Latency: combinational. Backpressure: none, pure logic.
module digit_add_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] sum,
    output logic             co
);

    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/digit_serial_adder.sv
// Add/subtract WIDTH-bit operands DIGIT bits per clock through one shared slice.
// Latency: out_valid rises WIDTH/DIGIT cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready low while busy.
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = ndig_f(WIDTH, DIGIT);
    localparam int IW   = idx_width_f(NDIG);
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("digit_serial_adder: WIDTH must be an integer multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] d_sum;
    logic             d_co;

    assign a_dig = a_q[idx*DIGIT +: DIGIT];
    assign b_dig = b_q[idx*DIGIT +: DIGIT];

    digit_add_slice #(.DIGIT(DIGIT)) u_slice (
        .a   (a_dig),
        .b   (b_dig),
        .ci  (carry),
        .sum (d_sum),
        .co  (d_co)
    );

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready = rst_n && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub | cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    s[idx*DIGIT +: DIGIT] <= d_sum;
                    carry                 <= d_co;
                    if (idx == LAST) begin
                        idx       <= '0;
                        cout      <= d_co;
                        // Top bit of the final digit is the result sign bit.
                        ovf       <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (d_sum[DIGIT-1] != a_q[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: fixed vectors, corner sequences and random ops vs arithmetic model.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, s;

    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, s8;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cout(cout8), .ovf(ovf8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] s;
        logic        cout, ovf;
    } vec_t;

    typedef struct {
        logic [7:0] a, b;
        logic       sub;
        logic [7:0] s;
        logic       cout, ovf;
    } vec8_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, unsigned for s/cout, signed range for ovf.
    function automatic logic [17:0] model(input logic [15:0] ma, mb, input logic mcin, msub);
        int sa, sb, u, sres;
        logic [15:0] rs;
        logic rc, ro;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (msub) begin
            u    = int'(ma) - int'(mb);
            rc   = (ma >= mb);
            sres = sa - sb;
        end else begin
            u    = int'(ma) + int'(mb) + int'(mcin);
            rc   = (u > 65535);
            sres = sa + sb + int'(mcin);
        end
        rs = 16'(u);
        ro = (sres > 32767) || (sres < -32768);
        return {rs, rc, ro};
    endfunction

    // Called near a negedge with the 16-bit DUT idle; leaves it idle after handoff.
    task automatic run_op(input logic [15:0] ia, ib, input logic icin, isub, input int hold,
                          input logic [15:0] es, input logic ec, eo);
        int lat;
        chk("in_ready_idle", in_ready, 1);
        a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready_busy", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_seen", out_valid, 1);
        chk("latency", lat, 4);
        chk("s", s, es);
        chk("cout", cout, ec);
        chk("ovf", ovf, eo);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_s", s, es);
            chk("hold_cout", cout, ec);
            chk("hold_ovf", ovf, eo);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
        chk("s_retained", s, es);
        chk("cout_retained", cout, ec);
    endtask

    vec_t  vecs[6];
    vec8_t vecs8[3];

    initial begin
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rc, rsub;
        int          seen, lat;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

        vecs8[0] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs8[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs8[2] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_s", s, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready8", in_ready8, 0);
        rst_n = 1'b1;
        #1;
        chk("first_in_ready", in_ready, 1);
        chk("first_in_ready8", in_ready8, 1);
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 0,
                   vecs[i].s, vecs[i].cout, vecs[i].ovf);

        // Backpressure for five cycles, then a follow-up operation.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 5, 16'h0000, 1'b1, 1'b0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 16'h2345, 1'b0, 1'b0);

        // Abort during digit 2.
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_s", s, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_first_in_ready", in_ready, 1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, 16'h2345, 1'b0, 1'b0);

        // Single-digit instance: latency 1.
        for (int i = 0; i < 3; i++) begin
            chk("w8_in_ready", in_ready8, 1);
            a8 = vecs8[i].a; b8 = vecs8[i].b; sub8 = vecs8[i].sub; cin8 = 1'b0; in_valid8 = 1'b1;
            @(negedge clk);
            in_valid8 = 1'b0;
            lat = 0;
            while (!out_valid8 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            chk("w8_latency", lat, 1);
            chk("w8_s", s8, vecs8[i].s);
            chk("w8_cout", cout8, vecs8[i].cout);
            chk("w8_ovf", ovf8, vecs8[i].ovf);
            out_ready8 = 1'b1;
            @(negedge clk);
            out_ready8 = 1'b0;
            chk("w8_valid_drop", out_valid8, 0);
        end

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rsub = 1'($urandom);
            if (i % 8 == 0) ra = 16'h8000;
            if (i % 8 == 1) rb = 16'hFFFF;
            m = model(ra, rb, rc, rsub);
            run_op(ra, rb, rc, rsub, int'($urandom_range(0, 2)), m[17:2], m[1], m[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
